// File: rtl/core_test_monitor.sv
// Run-control and self-check monitor: sequences core reset, snoops retirement and register writes,
// waits for the tohost exit store, then compares the shadow register file against an expected table.
module core_test_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_CHECKS     = 8,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          core_rst_n_o,
  input  logic                          instr_retire_i,
  input  logic                          rf_we_i,
  input  logic [4:0]                    rf_waddr_i,
  input  logic [XLEN-1:0]               rf_wdata_i,
  input  logic                          mem_we_i,
  input  logic [XLEN-1:0]               mem_addr_i,
  input  logic [XLEN-1:0]               mem_wdata_i,
  output logic [$clog2(NUM_CHECKS):0]   exp_idx_o,
  input  logic [4:0]                    exp_reg_i,
  input  logic [XLEN-1:0]               exp_val_i,
  input  logic [XLEN-1:0]               exp_mask_i,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [1:0]                    fail_code_o,
  output logic [$clog2(NUM_CHECKS):0]   fail_idx_o,
  output logic [XLEN-1:0]               exit_val_o,
  output logic [31:0]                   cycle_count_o,
  output logic [31:0]                   retire_count_o
);

  localparam int unsigned IdxW      = $clog2(NUM_CHECKS) + 1;
  localparam int unsigned HoldW     = $clog2(RESET_CYCLES + 2);
  localparam int unsigned DrainW    = $clog2(DRAIN_CYCLES + 2);
  localparam int unsigned LastIdx   = (NUM_CHECKS == 0) ? 0 : NUM_CHECKS - 1;
  localparam int unsigned DrainLast = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;

  typedef enum logic [2:0] {StHold, StRun, StDrain, StCheck, StPass, StFail} state_e;

  state_e            state_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic [IdxW-1:0]   exp_idx_q;
  logic [IdxW-1:0]   fail_idx_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              pass_q;
  logic [1:0]        fail_code_q;
  logic [XLEN-1:0]   exit_val_q;
  logic [31:0]       cycle_count_q;
  logic [31:0]       retire_count_q;
  logic [XLEN-1:0]   shadow_q [32];

  logic            core_active;
  logic            tohost_hit;
  logic            timeout_hit;
  logic [XLEN-1:0] shadow_rd;
  logic            entry_match;

  always_comb begin
    core_active = (state_q == StRun) || (state_q == StDrain);
    tohost_hit  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
    timeout_hit = (cycle_count_q == 32'(TIMEOUT_CYCLES - 1));
    shadow_rd   = (exp_reg_i == 5'd0) ? '0 : shadow_q[exp_reg_i];
    entry_match = ((shadow_rd ^ exp_val_i) & exp_mask_i) == '0;
  end

  // Snooped writes only land while the core is actually running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if (core_active && rf_we_i && (rf_waddr_i != 5'd0)) begin
      shadow_q[rf_waddr_i] <= rf_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StHold;
      hold_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      exp_idx_q      <= '0;
      fail_idx_q     <= '0;
      core_rst_n_q   <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_code_q    <= 2'd0;
      exit_val_q     <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
    end else begin
      if (core_active) begin
        cycle_count_q <= cycle_count_q + 32'd1;
        if (instr_retire_i) retire_count_q <= retire_count_q + 32'd1;
      end
      case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldW'(RESET_CYCLES - 1)) begin
            state_q      <= StRun;
            core_rst_n_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StRun: begin
          // The tohost store takes priority over a coincident timeout.
          if (tohost_hit) begin
            exit_val_q <= mem_wdata_i;
            if (DRAIN_CYCLES != 0) begin
              state_q     <= StDrain;
              drain_cnt_q <= '0;
            end else if (mem_wdata_i == XLEN'(1)) begin
              state_q      <= StCheck;
              core_rst_n_q <= 1'b0;
            end else begin
              state_q      <= StFail;
              core_rst_n_q <= 1'b0;
              done_q       <= 1'b1;
              fail_code_q  <= 2'd2;
            end
          end else if (timeout_hit) begin
            state_q      <= StFail;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b1;
            fail_code_q  <= 2'd1;
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainW'(DrainLast)) begin
            core_rst_n_q <= 1'b0;
            if (exit_val_q == XLEN'(1)) begin
              state_q <= StCheck;
            end else begin
              state_q     <= StFail;
              done_q      <= 1'b1;
              fail_code_q <= 2'd2;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
          end
        end
        StCheck: begin
          if (NUM_CHECKS == 0) begin
            state_q <= StPass;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (!entry_match) begin
            state_q     <= StFail;
            done_q      <= 1'b1;
            fail_code_q <= 2'd3;
            fail_idx_q  <= exp_idx_q;
          end else if (exp_idx_q == IdxW'(LastIdx)) begin
            state_q <= StPass;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            exp_idx_q <= exp_idx_q + IdxW'(1);
          end
        end
        StPass, StFail: ;
        default: state_q <= StHold;
      endcase
    end
  end

  assign core_rst_n_o   = core_rst_n_q;
  assign exp_idx_o      = exp_idx_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_code_o    = fail_code_q;
  assign fail_idx_o     = fail_idx_q;
  assign exit_val_o     = exit_val_q;
  assign cycle_count_o  = cycle_count_q;
  assign retire_count_o = retire_count_q;

endmodule

// File: tb/tb_core_test_monitor.sv
// Directed bench for core_test_monitor: pass path, masked mismatch, timeout, exit code,
// x0 handling with store/timeout tie-break, and reset in the middle of a run.
module tb_core_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_rst_n;
  logic        instr_retire;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  exp_idx;
  logic [4:0]  exp_reg;
  logic [31:0] exp_val;
  logic [31:0] exp_mask;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [1:0]  fail_idx;
  logic [31:0] exit_val;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  logic [4:0]  tbl_reg  [4];
  logic [31:0] tbl_val  [4];
  logic [31:0] tbl_mask [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    exp_reg  = tbl_reg[exp_idx];
    exp_val  = tbl_val[exp_idx];
    exp_mask = tbl_mask[exp_idx];
  end

  core_test_monitor #(
    .XLEN          (32),
    .NUM_CHECKS    (2),
    .RESET_CYCLES  (2),
    .DRAIN_CYCLES  (2),
    .TIMEOUT_CYCLES(20),
    .TOHOST_ADDR   (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_rst_n_o  (core_rst_n),
    .instr_retire_i(instr_retire),
    .rf_we_i       (rf_we),
    .rf_waddr_i    (rf_waddr),
    .rf_wdata_i    (rf_wdata),
    .mem_we_i      (mem_we),
    .mem_addr_i    (mem_addr),
    .mem_wdata_i   (mem_wdata),
    .exp_idx_o     (exp_idx),
    .exp_reg_i     (exp_reg),
    .exp_val_i     (exp_val),
    .exp_mask_i    (exp_mask),
    .done_o        (done),
    .pass_o        (pass),
    .fail_code_o   (fail_code),
    .fail_idx_o    (fail_idx),
    .exit_val_o    (exit_val),
    .cycle_count_o (cycle_count),
    .retire_count_o(retire_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_retire = 1'b0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  // One core cycle with the given snoop activity, then back to idle.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic mwe, input logic [31:0] ma, input logic [31:0] mwd,
                     input logic ret);
    rf_we = we; rf_waddr = wa; rf_wdata = wd;
    mem_we = mwe; mem_addr = ma; mem_wdata = mwd;
    instr_retire = ret;
    tick();
    idle_inputs();
  endtask

  task automatic set_tbl(input int i, input logic [4:0] r, input logic [31:0] v,
                         input logic [31:0] m);
    tbl_reg[i] = r; tbl_val[i] = v; tbl_mask[i] = m;
  endtask

  // Full reset then release; returns in the first RUN cycle.
  task automatic start();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_done(input int limit, input string name);
    for (int i = 0; i < limit && done !== 1'b1; i++) tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_done: done=%b after %0d cycles, want 1", name, done, limit);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({core_rst_n, done, pass, fail_code, fail_idx, exp_idx} !== 8'd0) begin
      failures++;
      $display("FAIL reset_flags: got rst/done/pass/code/idx/exp=%b want 0",
               {core_rst_n, done, pass, fail_code, fail_idx, exp_idx});
    end
    checks++;
    if (exit_val !== 32'd0 || cycle_count !== 32'd0 || retire_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: exit=%h cyc=%0d ret=%0d want 0", exit_val, cycle_count,
               retire_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_edge1: core_rst_n=%b want 0", core_rst_n);
    end
    tick();
    checks++;
    if (core_rst_n !== 1'b1 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_release_edge2: core_rst_n=%b cyc=%0d want 1/0", core_rst_n,
               cycle_count);
    end
  endtask

  // Expects to be called in the first RUN cycle; exit store lands at cycle_count 13.
  task automatic pass_seq(input string name);
    set_tbl(0, 5'd8, 32'h1234_5678, 32'hFFFF_FFFF);
    set_tbl(1, 5'd9, 32'h0000_FFFF, 32'h0000_FFFF);
    for (int c = 0; c < 14; c++) begin
      cyc((c == 2) || (c == 5), (c == 2) ? 5'd8 : 5'd9,
          (c == 2) ? 32'h1234_5678 : 32'h0000_FFFF,
          (c == 7) || (c == 13), (c == 7) ? 32'h8000_0100 : 32'h0000_0100, 32'h1, 1'b1);
    end
    tick();
    checks++;
    if (core_rst_n !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: core_rst_n=%b done=%b want 1/0", name, core_rst_n, done);
    end
    tick();
    checks++;
    if (core_rst_n !== 1'b0 || exp_idx !== 2'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_check_entry: core_rst_n=%b exp_idx=%0d done=%b want 0/0/0", name,
               core_rst_n, exp_idx, done);
    end
    tick();
    checks++;
    if (exp_idx !== 2'd1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_check_step: exp_idx=%0d done=%b want 1/0", name, exp_idx, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 2'd0 || exit_val !== 32'h1) begin
      failures++;
      $display("FAIL %s_result: done=%b pass=%b code=%0d exit=%h want 1/1/0/1", name, done,
               pass, fail_code, exit_val);
    end
    checks++;
    if (cycle_count !== 32'd16 || retire_count !== 32'd14) begin
      failures++;
      $display("FAIL %s_counts: cyc=%0d ret=%0d want 16/14", name, cycle_count, retire_count);
    end
    repeat (3) tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || cycle_count !== 32'd16 || core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL %s_held: done=%b pass=%b cyc=%0d core_rst_n=%b want 1/1/16/0", name, done,
               pass, cycle_count, core_rst_n);
    end
  endtask

  task automatic test_pass();
    start();
    pass_seq("pass");
  endtask

  task automatic test_masked_mismatch();
    start();
    set_tbl(0, 5'd5, 32'h1234_5678, 32'h0000_00FF);
    set_tbl(1, 5'd5, 32'h0000_0079, 32'h0000_00FF);
    cyc(1'b1, 5'd5, 32'h0000_0078, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0100, 32'h1, 1'b0);
    wait_done(20, "mask");
    checks++;
    if (pass !== 1'b0 || fail_code !== 2'd3 || fail_idx !== 2'd1) begin
      failures++;
      $display("FAIL mask_result: pass=%b code=%0d idx=%0d want 0/3/1", pass, fail_code,
               fail_idx);
    end
  endtask

  task automatic test_timeout();
    start();
    repeat (19) cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (done !== 1'b0 || core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: done=%b core_rst_n=%b want 0/1", done, core_rst_n);
    end
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd1) begin
      failures++;
      $display("FAIL timeout_result: done=%b pass=%b code=%0d want 1/0/1", done, pass,
               fail_code);
    end
    checks++;
    if (cycle_count !== 32'd20 || core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: cyc=%0d core_rst_n=%b want 20/0", cycle_count, core_rst_n);
    end
  endtask

  task automatic test_exit_code();
    start();
    set_tbl(0, 5'd0, 32'h0, 32'h0);
    set_tbl(1, 5'd0, 32'h0, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0100, 32'h7, 1'b0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0100, 32'h9, 1'b0);
    wait_done(10, "exit");
    checks++;
    if (pass !== 1'b0 || fail_code !== 2'd2 || exit_val !== 32'h7) begin
      failures++;
      $display("FAIL exit_result: pass=%b code=%0d exit=%h want 0/2/7", pass, fail_code,
               exit_val);
    end
    checks++;
    if (cycle_count !== 32'd5) begin
      failures++;
      $display("FAIL exit_cycles: cyc=%0d want 5", cycle_count);
    end
  endtask

  task automatic test_x0_tiebreak();
    start();
    set_tbl(0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    set_tbl(1, 5'd3, 32'h0000_DEAD, 32'h0000_FFFF);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (17) cyc(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    // cycle_count is 19 here: the store coincides with the timeout cycle.
    cyc(1'b1, 5'd3, 32'h0000_DEAD, 1'b1, 32'h0000_0100, 32'h1, 1'b0);
    checks++;
    if (done !== 1'b0 || core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL tie_drain: done=%b core_rst_n=%b want 0/1", done, core_rst_n);
    end
    wait_done(20, "tie");
    checks++;
    if (pass !== 1'b1 || fail_code !== 2'd0 || cycle_count !== 32'd22) begin
      failures++;
      $display("FAIL tie_result: pass=%b code=%0d cyc=%0d want 1/0/22", pass, fail_code,
               cycle_count);
    end
  endtask

  task automatic test_reset_mid_run();
    start();
    repeat (5) cyc(1'b1, 5'd8, 32'hBAD0_0000, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (cycle_count !== 32'd5 || retire_count !== 32'd5) begin
      failures++;
      $display("FAIL midrst_before: cyc=%0d ret=%0d want 5/5", cycle_count, retire_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cycle_count !== 32'd0 || retire_count !== 32'd0 || core_rst_n !== 1'b0 ||
        done !== 1'b0 || exp_idx !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async: cyc=%0d ret=%0d core_rst_n=%b done=%b exp=%0d want 0",
               cycle_count, retire_count, core_rst_n, done, exp_idx);
    end
    start();
    pass_seq("rerun");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) set_tbl(i, 5'd0, 32'h0, 32'h0);
    test_reset();
    test_pass();
    test_masked_mismatch();
    test_timeout();
    test_exit_code();
    test_x0_tiebreak();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
